spi_controller: RTL
===================

Name: spi_controller

Overview:
SPI Mode 0 controller, the initiator side of the 16-bit register-write protocol served by spi_peripheral. It accepts a one-shot command on the clk domain and drives nCS, SCLK and COPI. The frame is MSB first: R/W bit (1 = write), 7-bit address, 8-bit data. Used as the bench and board-side driver, and as a loopback source for the peripheral's register file. It also captures CIPO during the data byte for read frames.

Parameters:
CLK_DIV, 8, SCLK half-period in clk cycles; legal range is 4 or more (the peripheral synchronizer needs at least 4).
CS_SETUP, 8, clk cycles from the nCS falling edge to the first SCLK rising edge; legal range is 2 or more.
CS_HOLD, 8, clk cycles from the last SCLK falling edge to the nCS rising edge; legal range is 2 or more.
IDLE_GAP, 8, minimum clk cycles nCS stays high after a frame before busy deasserts; legal range is 1 or more.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  command strobe; sampled only when busy=0.
rw  input  1  frame bit 15; 1 = write, 0 = read.
addr  input  7  frame bits 14:8.
wdata  input  8  frame bits 7:0.
cipo  input  1  serial data from the peripheral; sampled on SCLK rising edges.
busy  output  1  high from the cycle after start is accepted until the end of IDLE_GAP.
done  output  1  one-cycle pulse in the cycle nCS returns high.
rdata  output  8  byte captured on CIPO; updated in the done cycle.
nCS  output  1  active-low chip select.
SCLK  output  1  serial clock; idles low.
COPI  output  1  serial data to the peripheral.

Behaviour:
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: nCS=1, SCLK=0, COPI=0, busy=0, done=0, rdata=0x00, FSM=IDLE, all counters 0.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - start=1 latches frame = {rw, addr, wdata}.
  - Next cycle (T0): nCS=0, busy=1, COPI=frame[15], SCLK=0. Enter SETUP.
  - Input changes while busy=1 are ignored.
- SETUP: hold for CS_SETUP cycles. SCLK rises at T0+CS_SETUP. Enter SHIFT.
- SHIFT, for bit index k = 0..15 (frame bit 15-k):
  - SCLK rises at T0+CS_SETUP+2k·CLK_DIV.
  - SCLK falls CLK_DIV cycles after each rise.
  - COPI changes only in the cycle SCLK falls, presenting the next bit. It is stable for the entire high phase.
  - A bit counter of 4 bits or more counts down from 15.
- CIPO capture:
  - On each rising edge with k = 8..15, cipo is shifted into an internal byte, MSB first.
  - Capture happens for both write and read frames.
- Last SCLK falling edge is at T0+CS_SETUP+31·CLK_DIV; enter HOLD. COPI=0 from that cycle.
- HOLD: after CS_HOLD cycles, nCS=1, done=1 for exactly one cycle, and rdata is loaded from the capture byte. Enter GAP.
- GAP: nCS=1 for IDLE_GAP cycles, then busy=0 and return to IDLE.
  - The earliest next nCS fall is one cycle after busy drops, if start is already high.
- Frame duration: nCS is low for exactly CS_SETUP+31·CLK_DIV+CS_HOLD cycles. Exactly 16 SCLK rising edges occur per frame.
- start held high continuously produces back-to-back frames separated by at least IDLE_GAP+1 high cycles of nCS.
- start in the same cycle as rst: rst wins and the command is dropped.
- Reset mid-frame, in any state: the next cycle sets all outputs to their reset values. No partial frame resumes. rdata is cleared to 0x00 and done does not pulse.
- SCLK never glitches.
- SCLK=0 whenever nCS=1.
- nCS never toggles while SCLK=1.

Test Plan:
- CLK_DIV=4, CS_SETUP=4, CS_HOLD=4, IDLE_GAP=4; start with rw=1, addr=0x02, wdata=0xA5 -> a monitor sampling COPI on SCLK rising edges sees 0x82A5. nCS is low for exactly 132 cycles with 16 SCLK rising edges. done pulses once, coincident with nCS rising. busy falls 4 cycles after done.
- Read frame rw=0, addr=0x04, with a CIPO model driving 0x3C on bits 7..0 (changing on SCLK falling edges) -> COPI stream is 0x0400, and rdata=0x3C in the done cycle and held after.
- start pulsed again while busy (mid-SHIFT, and during GAP), with different addr/wdata -> ignored. The COPI stream is unchanged and only one done pulse occurs.
- start held high for 3 frames with different data latched at each acceptance -> 3 complete frames. nCS is high for at least 5 cycles between frames.
- rst asserted at SCLK rising edge #7 -> next cycle nCS=1, SCLK=0, COPI=0, busy=0, rdata=0x00, and no done pulse. A following start produces a clean full frame.
- Default parameters, loopback to spi_peripheral: writes 0xFF to addr 0, 0x0F to addr 2 and 0x80 to addr 4 -> the corresponding peripheral output registers read 0xFF, 0x0F and 0x80. A write to addr 0x7F changes no register.

Source files
------------

// File: rtl/spi_controller.sv
// SPI Mode 0 initiator: one 16-bit frame {rw, addr, wdata} per accepted start, CIPO captured on bits 7..0.
// Latency: nCS falls the cycle after start; done pulses CS_SETUP+31*CLK_DIV+CS_HOLD cycles later.
// Backpressure: start is only sampled while busy=0; commands arriving while busy are dropped.
module spi_controller #(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 8,
    parameter int CS_HOLD  = 8,
    parameter int IDLE_GAP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       cipo,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [15:0] SETUP_LD = 16'(CS_SETUP - 1);
    localparam logic [15:0] DIV_LD   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LD  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LD   = 16'(IDLE_GAP - 1);

    state_t      state;
    logic [15:0] timer;
    logic [3:0]  bit_cnt;
    logic [14:0] frame;
    logic [7:0]  cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            cap     <= '0;
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            COPI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        frame <= {addr, wdata};
                        COPI  <= rw;
                        nCS   <= 1'b0;
                        busy  <= 1'b1;
                        timer <= SETUP_LD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer == '0) begin
                        SCLK    <= 1'b1;
                        timer   <= DIV_LD;
                        bit_cnt <= 4'd15;
                        state   <= SHIFT;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                SHIFT: begin
                    if (timer != '0) begin
                        timer <= timer - 16'd1;
                    end else if (SCLK) begin
                        // Falling edge: COPI moves only here so it is stable across the high phase.
                        SCLK <= 1'b0;
                        if (bit_cnt == 4'd0) begin
                            COPI  <= 1'b0;
                            timer <= HOLD_LD;
                            state <= HOLD;
                        end else begin
                            COPI    <= frame[14];
                            frame   <= {frame[13:0], 1'b0};
                            bit_cnt <= bit_cnt - 4'd1;
                            timer   <= DIV_LD;
                        end
                    end else begin
                        SCLK  <= 1'b1;
                        timer <= DIV_LD;
                        if (bit_cnt < 4'd8) begin
                            cap <= {cap[6:0], cipo};
                        end
                    end
                end
                HOLD: begin
                    if (timer == '0) begin
                        nCS   <= 1'b1;
                        done  <= 1'b1;
                        rdata <= cap;
                        timer <= GAP_LD;
                        state <= GAP;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
